// File: rtl/ysyx_23060025_pipe_ctrl.sv
// ysyx_23060025_pipe_ctrl
// Central pipeline sequencer for the five-stage core (IFU/IDU/EXU/LSU/WBU).
// Merges load-use stalls, EXU branch redirects, WBU commit-time traps
// (ecall/mret) and fence.i into per-stage stall/flush controls, one IFU
// redirect port and the icache invalidate handshake.
//
// Ports:
//   clock, reset              system clock, synchronous active-high reset
//   hazard_nop_i              load-use stall request from the conflict unit
//   exu_branch_i/_target_i    taken branch/jump resolved in EXU and its target
//   wbu_trap_i/_target_i      ecall/mret committing, mtvec/mepc target
//   wbu_fencei_i, wbu_pc_i    fence.i committing and PC of the committing insn
//   lsu_busy_i                LSU bus transaction outstanding
//   icache_flush_done_i       icache invalidate complete (1-cycle pulse)
//   stall_{if,id,ex}_o        hold stage registers
//   flush_{id,ex,ls}_o        clear stage valid on the next edge
//   redirect_valid_o/_pc_o    IFU must load the new fetch PC
//   icache_flush_o            icache invalidate request (level)
//   perf_stall_cnt_o          cycles with stall_id_o high   (PIPE_PERF_CNT_EN)
//   perf_flush_cnt_o          cycles with flush_id_o high   (PIPE_PERF_CNT_EN)
//
// Optional feature macro: PIPE_PERF_CNT_EN enables the two performance
// counters and their ports. Control behaviour does not depend on it.
module ysyx_23060025_pipe_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        hazard_nop_i,
  input  logic        exu_branch_i,
  input  logic [31:0] exu_branch_target_i,
  input  logic        wbu_trap_i,
  input  logic [31:0] wbu_trap_target_i,
  input  logic        wbu_fencei_i,
  input  logic [31:0] wbu_pc_i,
  input  logic        lsu_busy_i,
  input  logic        icache_flush_done_i,
  output logic        stall_if_o,
  output logic        stall_id_o,
  output logic        stall_ex_o,
  output logic        flush_id_o,
  output logic        flush_ex_o,
  output logic        flush_ls_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0] perf_stall_cnt_o,
  output logic [31:0] perf_flush_cnt_o,
`endif
  output logic        icache_flush_o
);

  typedef enum logic [1:0] {
    RUN,
    WAIT_LSU,
    FENCE
  } state_t;

  state_t      r_state;
  logic        r_pendFence;
  logic [31:0] r_pendPc;
  logic [31:0] w_fencePc;

  // fence.i resumes at the instruction after itself; 32-bit wrap is intended.
  assign w_fencePc = wbu_pc_i + 32'd4;

  // Sequencer state plus the pending redirect kind/target. Only traps and
  // fence.i leave RUN; a second trap/fence.i outside RUN is ignored because
  // the younger stages are held. pend_pc reloads with RESET_PC on reset,
  // which simply discards any pending target.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= RUN;
      r_pendFence <= 1'b0;
      r_pendPc    <= RESET_PC;
    end else begin
      case (r_state)
        RUN: begin
          if (wbu_trap_i) begin
            if (lsu_busy_i) begin
              r_pendPc    <= wbu_trap_target_i;
              r_pendFence <= 1'b0;
              r_state     <= WAIT_LSU;
            end
          end else if (wbu_fencei_i) begin
            r_pendPc    <= w_fencePc;
            r_pendFence <= 1'b1;
            r_state     <= lsu_busy_i ? WAIT_LSU : FENCE;
          end
        end
        WAIT_LSU: begin
          if (!lsu_busy_i) begin
            r_state <= r_pendFence ? FENCE : RUN;
          end
        end
        FENCE: begin
          if (icache_flush_done_i) begin
            r_state <= RUN;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  // Output decode, combinational from state and inputs so that branches and
  // idle-LSU traps redirect in the same cycle. Everything is forced low while
  // reset is asserted.
  always_comb begin
    stall_if_o       = 1'b0;
    stall_id_o       = 1'b0;
    stall_ex_o       = 1'b0;
    flush_id_o       = 1'b0;
    flush_ex_o       = 1'b0;
    flush_ls_o       = 1'b0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = 32'd0;
    icache_flush_o   = 1'b0;
    if (!reset) begin
      case (r_state)
        RUN: begin
          if (wbu_trap_i) begin
            if (!lsu_busy_i) begin
              flush_id_o       = 1'b1;
              flush_ex_o       = 1'b1;
              flush_ls_o       = 1'b1;
              redirect_valid_o = 1'b1;
              redirect_pc_o    = wbu_trap_target_i;
            end
          end else if (wbu_fencei_i) begin
            if (!lsu_busy_i) begin
              flush_id_o = 1'b1;
              flush_ex_o = 1'b1;
              flush_ls_o = 1'b1;
            end
          end else if (exu_branch_i) begin
            // The IDU instruction is younger than the branch, so a
            // coincident load-use stall is moot: it is flushed instead.
            flush_id_o       = 1'b1;
            redirect_valid_o = 1'b1;
            redirect_pc_o    = exu_branch_target_i;
          end else if (hazard_nop_i) begin
            stall_if_o = 1'b1;
            stall_id_o = 1'b1;
            flush_ex_o = 1'b1;
          end
        end
        WAIT_LSU: begin
          stall_if_o = 1'b1;
          stall_id_o = 1'b1;
          stall_ex_o = 1'b1;
          if (!lsu_busy_i) begin
            flush_id_o = 1'b1;
            flush_ex_o = 1'b1;
            flush_ls_o = 1'b1;
            if (!r_pendFence) begin
              redirect_valid_o = 1'b1;
              redirect_pc_o    = r_pendPc;
            end
          end
        end
        FENCE: begin
          stall_if_o = 1'b1;
          if (icache_flush_done_i) begin
            redirect_valid_o = 1'b1;
            redirect_pc_o    = r_pendPc;
          end else begin
            icache_flush_o = 1'b1;
          end
        end
        default: begin
          stall_if_o = 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_stallCnt;
  logic [31:0] r_flushCnt;

  // Free-running 32-bit event counters, wrapping naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stallCnt <= 32'd0;
      r_flushCnt <= 32'd0;
    end else begin
      r_stallCnt <= r_stallCnt + {31'd0, stall_id_o};
      r_flushCnt <= r_flushCnt + {31'd0, flush_id_o};
    end
  end

  assign perf_stall_cnt_o = r_stallCnt;
  assign perf_flush_cnt_o = r_flushCnt;
`endif

endmodule

// File: doc/ysyx_23060025_pipe_ctrl.md
# ysyx_23060025_pipe_ctrl

Central pipeline sequencer for the five-stage core (IFU, IDU, EXU, LSU, WBU). It merges the load-use stall request from the hazard/bypass unit, EXU branch redirects, WBU commit-time traps (ecall/mret) and fence.i. It produces per-stage stall and flush controls, a single PC-redirect port for the IFU, and the icache invalidate handshake. Traps and fence.i wait for an in-flight LSU bus transaction to finish before the younger stages are flushed.

## Interface
Parameters:
- RESET_PC, 32'h3000_0000, redirect target not used at reset; exposed for consistency with IFU

Ports:
- clock  input  1  system clock
- reset  input  1  reset, synchronous, active-high
- hazard_nop_i  input  1  load-use stall request from conflict unit
- exu_branch_i  input  1  EXU resolved taken jump/branch this cycle
- exu_branch_target_i  input  32  branch target
- wbu_trap_i  input  1  ecall/mret committing this cycle
- wbu_trap_target_i  input  32  mtvec/mepc target
- wbu_fencei_i  input  1  fence.i committing this cycle
- wbu_pc_i  input  32  PC of committing instruction
- lsu_busy_i  input  1  LSU has an outstanding bus transaction
- icache_flush_done_i  input  1  icache invalidate complete (1-cycle pulse)
- stall_if_o, stall_id_o, stall_ex_o  output  1 each  hold stage register
- flush_id_o, flush_ex_o, flush_ls_o  output  1 each  clear stage valid next edge
- redirect_valid_o  output  1  IFU must load redirect_pc_o
- redirect_pc_o  output  32  new fetch PC
- icache_flush_o  output  1  icache invalidate request, level
- perf_stall_cnt_o, perf_flush_cnt_o  output  32 each  only with PIPE_PERF_CNT_EN

## Operation
States: RUN, WAIT_LSU, FENCE. Reset enters RUN. All outputs are 0 at reset, and counters are cleared.

RUN priority, highest first:
- **wbu_trap_i**
  - If lsu_busy_i=0: flush_id/ex/ls=1, redirect_valid=1, redirect_pc=wbu_trap_target_i, all same cycle.
  - Otherwise: latch the target into pend_pc, latch kind=TRAP, go to WAIT_LSU.
- **wbu_fencei_i**
  - Latch pend_pc=wbu_pc_i+4 (32-bit wrap).
  - If lsu_busy_i=0: flush_id/ex/ls=1 and go to FENCE.
  - Otherwise: kind=FENCE and go to WAIT_LSU.
- **exu_branch_i**
  - flush_id=1, flush_ex=0, redirect_valid=1, redirect_pc=exu_branch_target_i.
  - A coincident hazard_nop_i is ignored, because the IDU instruction is younger and is flushed.
- **hazard_nop_i**
  - stall_if=1, stall_id=1, flush_ex=1 (a bubble is inserted into EXU).

WAIT_LSU:
- stall_if/id/ex=1.
- No redirect.
- exu_branch_i and hazard_nop_i are ignored.
- When lsu_busy_i=0:
  - kind=TRAP: flush_id/ex/ls=1, redirect_valid=1, redirect_pc=pend_pc, go to RUN.
  - kind=FENCE: flush_id/ex/ls=1, go to FENCE.

FENCE:
- icache_flush_o=1 and stall_if=1.
- On icache_flush_done_i: redirect_valid=1, redirect_pc=pend_pc, icache_flush_o=0 that cycle, go to RUN.

General rules:
- A second wbu_trap_i/wbu_fencei_i outside RUN is impossible by construction, since the younger stages are stalled. If one is asserted anyway, it is ignored.
- All outputs are combinational from state plus inputs. Only state, kind and pend_pc are registered.

## Timing
- Branch redirect latency is 0 cycles: same-cycle redirect_valid_o. The IFU fetches the target on the next edge.
- Trap with LSU idle: 0 cycles. With LSU busy for N cycles: the redirect fires in the cycle lsu_busy_i first reads 0.
- Fence.i: minimum 2 cycles from commit to redirect, namely the RUN→FENCE edge plus the done pulse in FENCE.
- A hazard stall lasts exactly as long as hazard_nop_i is high. There is no internal extension.
- A reset mid-WAIT_LSU or mid-FENCE returns to RUN on the next edge, drops icache_flush_o and discards pend_pc.
- redirect_valid_o is never high for two consecutive cycles from the same event.

## Configuration
- PIPE_PERF_CNT_EN defined:
  - perf_stall_cnt_o counts cycles with stall_id_o=1.
  - perf_flush_cnt_o counts cycles with flush_id_o=1.
  - Both are 32-bit, wrap at 2^32, and clear on reset.
- Undefined: both ports and the counter registers are absent. Control behaviour is identical.

## Test plan
- hazard_nop_i high for 2 cycles in RUN -> stall_if/id=1 and flush_ex=1 for exactly those 2 cycles; perf_stall_cnt_o=2.
- exu_branch_i=1, target 0x8000_0100, with hazard_nop_i=1 -> redirect_valid=1, pc=0x8000_0100, flush_id=1, stall_id=0, same cycle.
- wbu_trap_i, target 0x8000_0004, while lsu_busy_i high 3 more cycles -> WAIT_LSU with stalls high; the redirect to 0x8000_0004 and flush_id/ex/ls fire in the 4th cycle.
- wbu_fencei_i, wbu_pc_i=0xFFFF_FFFC, LSU idle -> flush all, FENCE, icache_flush_o high until done pulse 5 cycles later, then redirect_pc=0x0000_0000.
- reset asserted in FENCE -> next cycle RUN, icache_flush_o=0, no redirect, counters 0.
- wbu_trap_i and exu_branch_i same cycle, LSU idle -> redirect_pc=trap target, flush_ls=1.
